// File: rtl/sdhci_buf_fifo_ctrl.sv
// SDHCI data buffer FIFO controller.
// Sequences a two-port RAM as a FIFO between the SD data-line engine (writer,
// port A) and the host/DMA side (reader, port B). A two-entry output buffer
// absorbs the one-cycle RAM read latency so both sides can stream one word per cycle.
module sdhci_buf_fifo_ctrl #(
   parameter int unsigned Width = 32,
   parameter int unsigned Depth = 128,
   localparam int unsigned Aw = $clog2(Depth),
   localparam int unsigned Cw = $clog2(Depth + 3)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             wvalid_i,
   output logic             wready_o,
   input  logic [Width-1:0] wdata_i,
   output logic             rvalid_o,
   input  logic             rready_i,
   output logic [Width-1:0] rdata_o,
   output logic [Cw-1:0]    depth_o,
   output logic             ram_a_req_o,
   output logic             ram_a_write_o,
   output logic [Aw-1:0]    ram_a_addr_o,
   output logic [Width-1:0] ram_a_wdata_o,
   output logic [Width-1:0] ram_a_wmask_o,
   output logic             ram_b_req_o,
   output logic             ram_b_write_o,
   output logic [Aw-1:0]    ram_b_addr_o,
   output logic [Width-1:0] ram_b_wdata_o,
   output logic [Width-1:0] ram_b_wmask_o,
   input  logic [Width-1:0] ram_b_rdata_i
);

   localparam int unsigned Pw = Aw + 1;

   logic [Pw-1:0]    wr_ptr_q, wr_ptr_d;
   logic [Pw-1:0]    rd_ptr_q, rd_ptr_d;
   logic             inflight_q, inflight_d;
   logic [1:0]       ob_cnt_q, ob_cnt_d;
   logic [Width-1:0] ob0_q, ob0_d;
   logic [Width-1:0] ob1_q, ob1_d;

   logic [Pw-1:0]    stored;
   logic [2:0]       committed;
   logic [1:0]       ob_after_pop;
   logic             wr_hs;
   logic             pop;
   logic             issue;

   // Handshakes and fetch decision; RAM requests are held off while in reset.
   assign stored    = wr_ptr_q - rd_ptr_q;
   assign wready_o  = (stored != Pw'(Depth)) && !clr_i;
   assign rvalid_o  = (ob_cnt_q != 2'd0) && !clr_i;
   assign rdata_o   = ob0_q;
   assign wr_hs     = wvalid_i && wready_o && !rst_i;
   assign pop       = rvalid_o && rready_i;
   assign committed = 3'(ob_cnt_q) + 3'(inflight_q) - 3'(pop);
   assign issue     = (stored != '0) && (committed < 3'd2) && !clr_i && !rst_i;
   assign depth_o   = Cw'(stored) + Cw'(inflight_q) + Cw'(ob_cnt_q);

   // RAM port A: write-only.
   assign ram_a_req_o   = wr_hs;
   assign ram_a_write_o = wr_hs;
   assign ram_a_addr_o  = wr_ptr_q[Aw-1:0];
   assign ram_a_wdata_o = wdata_i;
   assign ram_a_wmask_o = '1;

   // RAM port B: read-only.
   assign ram_b_req_o   = issue;
   assign ram_b_write_o = 1'b0;
   assign ram_b_addr_o  = rd_ptr_q[Aw-1:0];
   assign ram_b_wdata_o = '0;
   assign ram_b_wmask_o = '0;

   // Next state: pointers, in-flight flag and output buffer (pop before push keeps FIFO order).
   always_comb begin
      wr_ptr_d     = wr_ptr_q + Pw'(wr_hs);
      rd_ptr_d     = rd_ptr_q + Pw'(issue);
      inflight_d   = issue;
      ob0_d        = ob0_q;
      ob1_d        = ob1_q;
      ob_after_pop = ob_cnt_q - 2'(pop);
      if (pop) begin
         ob0_d = ob1_q;
      end
      if (inflight_q) begin
         if (ob_after_pop == 2'd0) begin
            ob0_d = ram_b_rdata_i;
         end else begin
            ob1_d = ram_b_rdata_i;
         end
      end
      ob_cnt_d = ob_after_pop + 2'(inflight_q);
      if (clr_i) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         inflight_d = 1'b0;
         ob_cnt_d   = 2'd0;
         ob0_d      = ob0_q;
         ob1_d      = ob1_q;
      end
   end

   // State registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         inflight_q <= 1'b0;
         ob_cnt_q   <= 2'd0;
         ob0_q      <= '0;
         ob1_q      <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         inflight_q <= inflight_d;
         ob_cnt_q   <= ob_cnt_d;
         ob0_q      <= ob0_d;
         ob1_q      <= ob1_d;
      end
   end

endmodule

// File: tb/tb_sdhci_buf_fifo_ctrl.sv
// Directed bench for sdhci_buf_fifo_ctrl with a behavioural two-port RAM.
module tb_sdhci_buf_fifo_ctrl;

   localparam int unsigned Width = 8;
   localparam int unsigned Depth = 4;
   localparam int unsigned Aw    = 2;
   localparam int unsigned Cw    = 3;

   logic             clk = 1'b0;
   logic             rst, clr, wvalid, wready, rvalid, rready;
   logic [Width-1:0] wdata, rdata;
   logic [Cw-1:0]    depth;
   logic             ram_a_req, ram_a_write, ram_b_req, ram_b_write;
   logic [Aw-1:0]    ram_a_addr, ram_b_addr;
   logic [Width-1:0] ram_a_wdata, ram_a_wmask, ram_b_wdata, ram_b_wmask, ram_b_rdata;
   logic [Width-1:0] mem [Depth];

   int n_checks = 0;
   int n_fail   = 0;

   sdhci_buf_fifo_ctrl #(.Width(Width), .Depth(Depth)) dut (
      .clk_i(clk), .rst_i(rst), .clr_i(clr),
      .wvalid_i(wvalid), .wready_o(wready), .wdata_i(wdata),
      .rvalid_o(rvalid), .rready_i(rready), .rdata_o(rdata),
      .depth_o(depth),
      .ram_a_req_o(ram_a_req), .ram_a_write_o(ram_a_write), .ram_a_addr_o(ram_a_addr),
      .ram_a_wdata_o(ram_a_wdata), .ram_a_wmask_o(ram_a_wmask),
      .ram_b_req_o(ram_b_req), .ram_b_write_o(ram_b_write), .ram_b_addr_o(ram_b_addr),
      .ram_b_wdata_o(ram_b_wdata), .ram_b_wmask_o(ram_b_wmask),
      .ram_b_rdata_i(ram_b_rdata)
   );

   always #5 clk = ~clk;

   // Two-port RAM model: synchronous write on A, one-cycle read latency on B.
   always @(posedge clk) begin
      if (ram_a_req && ram_a_write) mem[ram_a_addr] <= ram_a_wdata;
      if (ram_b_req) ram_b_rdata <= mem[ram_b_addr];
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; clr = 1'b0; wvalid = 1'b1; wdata = 8'h77; rready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (wready !== 1'b1) begin n_fail++; $display("FAIL reset_wready: got %0b want 1", wready); end
      n_checks++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %0b want 0", rvalid); end
      n_checks++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata: got %h want 00", rdata); end
      n_checks++; if (depth !== 3'd0) begin n_fail++; $display("FAIL reset_depth: got %0d want 0", depth); end
      n_checks++; if (ram_a_req !== 1'b0) begin n_fail++; $display("FAIL reset_ram_a_req: got %0b want 0", ram_a_req); end
      n_checks++; if (ram_b_req !== 1'b0) begin n_fail++; $display("FAIL reset_ram_b_req: got %0b want 0", ram_b_req); end
      n_checks++; if (ram_a_wmask !== 8'hFF) begin n_fail++; $display("FAIL tie_a_wmask: got %h want ff", ram_a_wmask); end
      n_checks++; if (ram_b_write !== 1'b0 || ram_b_wdata !== 8'h00 || ram_b_wmask !== 8'h00) begin
         n_fail++; $display("FAIL tie_port_b: got write=%0b wdata=%h wmask=%h want 0/00/00", ram_b_write, ram_b_wdata, ram_b_wmask);
      end
      wvalid = 1'b0; rready = 1'b0;
      rst = 1'b0;
      step();
      #1;
      n_checks++; if (depth !== 3'd0 || rvalid !== 1'b0) begin
         n_fail++; $display("FAIL post_reset_empty: got depth=%0d rvalid=%0b want 0/0", depth, rvalid);
      end
   endtask

   task automatic test_write_latency();
      logic [7:0] exp [3];
      int got;
      exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33;
      rready = 1'b0;
      step();
      for (int c = 0; c < 4; c++) begin
         wvalid = (c < 3);
         wdata  = 8'h00;
         if (c < 3) wdata = exp[c];
         #1;
         if (c < 3) begin
            n_checks++; if (wready !== 1'b1 || ram_a_req !== 1'b1 || ram_a_addr !== 2'(c)) begin
               n_fail++; $display("FAIL lat_write_%0d: got wready=%0b req=%0b addr=%0d want 1/1/%0d", c, wready, ram_a_req, ram_a_addr, c);
            end
         end
         n_checks++; if (rvalid !== (c == 3)) begin
            n_fail++; $display("FAIL lat_rvalid_cycle%0d: got %0b want %0b", c, rvalid, (c == 3));
         end
         if (c == 3) begin
            n_checks++; if (depth !== 3'd3) begin n_fail++; $display("FAIL lat_depth: got %0d want 3", depth); end
            n_checks++; if (rdata !== 8'h11) begin n_fail++; $display("FAIL lat_head: got %h want 11", rdata); end
         end
         step();
      end
      rready = 1'b1; got = 0;
      for (int c = 0; c < 10 && got < 3; c++) begin
         #1;
         if (rvalid) begin
            n_checks++; if (rdata !== exp[got]) begin n_fail++; $display("FAIL lat_pop_%0d: got %h want %h", got, rdata, exp[got]); end
            got++;
         end
         step();
      end
      rready = 1'b0;
      #1;
      n_checks++; if (got !== 3) begin n_fail++; $display("FAIL lat_pop_count: got %0d want 3", got); end
      n_checks++; if (depth !== 3'd0) begin n_fail++; $display("FAIL lat_drained_depth: got %0d want 0", depth); end
   endtask

   task automatic test_full();
      int acc, got;
      acc = 0; rready = 1'b0;
      step();
      for (int c = 0; c < 12; c++) begin
         wvalid = 1'b1; wdata = 8'h40 + 8'(acc);
         #1;
         if (wready) acc++;
         step();
      end
      wvalid = 1'b0;
      #1;
      n_checks++; if (acc !== 6) begin n_fail++; $display("FAIL full_accepted: got %0d want 6", acc); end
      n_checks++; if (depth !== 3'd6) begin n_fail++; $display("FAIL full_depth: got %0d want 6", depth); end
      n_checks++; if (wready !== 1'b0) begin n_fail++; $display("FAIL full_wready: got %0b want 0", wready); end
      n_checks++; if (rvalid !== 1'b1 || rdata !== 8'h40) begin
         n_fail++; $display("FAIL full_head: got rvalid=%0b rdata=%h want 1/40", rvalid, rdata);
      end
      rready = 1'b1;
      step();
      rready = 1'b0;
      #1;
      n_checks++; if (wready !== 1'b1) begin n_fail++; $display("FAIL full_wready_return: got %0b want 1", wready); end
      n_checks++; if (depth !== 3'd5) begin n_fail++; $display("FAIL full_depth_after_pop: got %0d want 5", depth); end
      rready = 1'b1; got = 0;
      for (int c = 0; c < 20 && got < 5; c++) begin
         #1;
         if (rvalid) begin
            n_checks++; if (rdata !== 8'h41 + 8'(got)) begin
               n_fail++; $display("FAIL full_drain_%0d: got %h want %h", got, rdata, 8'h41 + 8'(got));
            end
            got++;
         end
         step();
      end
      rready = 1'b0;
      n_checks++; if (got !== 5) begin n_fail++; $display("FAIL full_drain_count: got %0d want 5", got); end
   endtask

   task automatic test_stream();
      int wi, ri, first_rd, last_rd, wraps, stalls;
      logic [1:0] prev_addr;
      logic seen_a;
      clr = 1'b1;
      step();
      clr = 1'b0;
      wi = 0; ri = 0; first_rd = -1; last_rd = -1; wraps = 0; stalls = 0;
      prev_addr = 2'd0; seen_a = 1'b0;
      rready = 1'b1;
      for (int c = 0; c < 300 && ri < 100; c++) begin
         wvalid = (wi < 100); wdata = 8'(wi);
         #1;
         if (wvalid) begin
            if (wready) begin
               if (seen_a && prev_addr == 2'd3 && ram_a_addr == 2'd0) wraps++;
               prev_addr = ram_a_addr; seen_a = 1'b1; wi++;
            end else begin
               stalls++;
            end
         end
         if (rvalid) begin
            n_checks++; if (rdata !== 8'(ri)) begin n_fail++; $display("FAIL stream_data_%0d: got %h want %h", ri, rdata, 8'(ri)); end
            if (first_rd < 0) first_rd = c;
            last_rd = c; ri++;
         end
         step();
      end
      wvalid = 1'b0; rready = 1'b0;
      n_checks++; if (wi !== 100 || ri !== 100) begin n_fail++; $display("FAIL stream_counts: got wr=%0d rd=%0d want 100/100", wi, ri); end
      n_checks++; if (stalls !== 0) begin n_fail++; $display("FAIL stream_write_stalls: got %0d want 0", stalls); end
      n_checks++; if (last_rd - first_rd !== 99) begin n_fail++; $display("FAIL stream_read_span: got %0d want 99", last_rd - first_rd); end
      n_checks++; if (wraps !== 24) begin n_fail++; $display("FAIL stream_addr_wraps: got %0d want 24", wraps); end
   endtask

   task automatic test_random();
      logic [7:0] sb [$];
      logic [7:0] nxt, exp_v;
      int wr_n, rd_n;
      nxt = 8'h00; wr_n = 0; rd_n = 0;
      for (int c = 0; c < 10000; c++) begin
         wvalid = 1'($urandom_range(0, 1)); rready = 1'($urandom_range(0, 1)); wdata = nxt;
         #1;
         n_checks++; if (depth !== 3'(wr_n - rd_n)) begin
            n_fail++; $display("FAIL rand_depth_c%0d: got %0d want %0d", c, depth, wr_n - rd_n);
         end
         if (ram_a_req && ram_b_req) begin
            n_checks++; if (ram_a_addr === ram_b_addr) begin
               n_fail++; $display("FAIL rand_addr_conflict_c%0d: got a=%0d b=%0d want different", c, ram_a_addr, ram_b_addr);
            end
         end
         if (rvalid && rready) begin
            n_checks++;
            if (sb.size() == 0) begin
               n_fail++; $display("FAIL rand_underflow_c%0d: got pop of %h want no data", c, rdata);
            end else begin
               exp_v = sb.pop_front();
               if (rdata !== exp_v) begin n_fail++; $display("FAIL rand_data_c%0d: got %h want %h", c, rdata, exp_v); end
            end
            rd_n++;
         end
         if (wvalid && wready) begin
            sb.push_back(nxt); nxt++; wr_n++;
         end
         step();
      end
      wvalid = 1'b0; rready = 1'b1;
      for (int c = 0; c < 20 && sb.size() != 0; c++) begin
         #1;
         if (rvalid) begin
            exp_v = sb.pop_front();
            n_checks++; if (rdata !== exp_v) begin n_fail++; $display("FAIL rand_drain: got %h want %h", rdata, exp_v); end
         end
         step();
      end
      rready = 1'b0;
      #1;
      n_checks++; if (sb.size() !== 0 || depth !== 3'd0) begin
         n_fail++; $display("FAIL rand_final: got left=%0d depth=%0d want 0/0", sb.size(), depth);
      end
      n_checks++; if (wr_n < 1000) begin n_fail++; $display("FAIL rand_activity: got %0d writes want >= 1000", wr_n); end
   endtask

   task automatic test_clear();
      int waited;
      rready = 1'b0; clr = 1'b0;
      step();
      for (int c = 0; c < 4; c++) begin
         wvalid = 1'b1; wdata = 8'h01 + 8'(c);
         step();
      end
      wvalid = 1'b0;
      step(); step();
      #1;
      n_checks++; if (depth !== 3'd4 || rdata !== 8'h01) begin
         n_fail++; $display("FAIL clr_setup: got depth=%0d rdata=%h want 4/01", depth, rdata);
      end
      rready = 1'b1;
      step();
      rready = 1'b0; clr = 1'b1; wvalid = 1'b1; wdata = 8'hEE;
      #1;
      n_checks++; if (rvalid !== 1'b0 || wready !== 1'b0) begin
         n_fail++; $display("FAIL clr_cycle_handshake: got rvalid=%0b wready=%0b want 0/0", rvalid, wready);
      end
      n_checks++; if (ram_a_req !== 1'b0 || ram_b_req !== 1'b0) begin
         n_fail++; $display("FAIL clr_cycle_ram_req: got a=%0b b=%0b want 0/0", ram_a_req, ram_b_req);
      end
      step();
      clr = 1'b0; wvalid = 1'b0;
      #1;
      n_checks++; if (rvalid !== 1'b0 || depth !== 3'd0 || wready !== 1'b1) begin
         n_fail++; $display("FAIL clr_after: got rvalid=%0b depth=%0d wready=%0b want 0/0/1", rvalid, depth, wready);
      end
      wvalid = 1'b1; wdata = 8'hA5;
      step();
      wvalid = 1'b0;
      waited = 0;
      while (!rvalid && waited < 8) begin
         step();
         waited++;
      end
      #1;
      n_checks++; if (rvalid !== 1'b1 || rdata !== 8'hA5) begin
         n_fail++; $display("FAIL clr_next_word: got rvalid=%0b rdata=%h want 1/a5", rvalid, rdata);
      end
      rready = 1'b1;
      step();
      rready = 1'b0;
      #1;
      n_checks++; if (depth !== 3'd0) begin n_fail++; $display("FAIL clr_final_depth: got %0d want 0", depth); end
   endtask

   task automatic test_async_reset();
      rready = 1'b0;
      step();
      for (int c = 0; c < 3; c++) begin
         wvalid = 1'b1; wdata = 8'hC0 + 8'(c);
         step();
      end
      wvalid = 1'b0;
      step(); step();
      #1;
      n_checks++; if (rvalid !== 1'b1 || depth !== 3'd3) begin
         n_fail++; $display("FAIL arst_setup: got rvalid=%0b depth=%0d want 1/3", rvalid, depth);
      end
      wvalid = 1'b1; wdata = 8'hEE;
      #2;
      rst = 1'b1;
      #1;
      n_checks++; if (rvalid !== 1'b0 || depth !== 3'd0 || rdata !== 8'h00 || wready !== 1'b1) begin
         n_fail++; $display("FAIL arst_outputs: got rvalid=%0b depth=%0d rdata=%h wready=%0b want 0/0/00/1", rvalid, depth, rdata, wready);
      end
      n_checks++; if (ram_a_req !== 1'b0 || ram_b_req !== 1'b0) begin
         n_fail++; $display("FAIL arst_ram_req: got a=%0b b=%0b want 0/0", ram_a_req, ram_b_req);
      end
      #1;
      rst = 1'b0; wvalid = 1'b0;
      step();
      for (int c = 0; c < 4; c++) begin
         wvalid = (c == 0); wdata = 8'h5A;
         #1;
         n_checks++; if (rvalid !== (c == 3)) begin
            n_fail++; $display("FAIL arst_relat_cycle%0d: got %0b want %0b", c, rvalid, (c == 3));
         end
         if (c == 3) begin
            n_checks++; if (rdata !== 8'h5A || depth !== 3'd1) begin
               n_fail++; $display("FAIL arst_reword: got rdata=%h depth=%0d want 5a/1", rdata, depth);
            end
         end
         step();
      end
      wvalid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_write_latency();
      test_full();
      test_stream();
      test_random();
      test_clear();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
